// File: rtl/mdiv_pkg.sv
// Shared constants and state encoding for the modular-divider operand sequencer.
package mdiv_pkg;

    localparam int MDIV_WORD_W  = 32;
    localparam int MDIV_N_WORDS = 8;
    localparam int MDIV_CNT_W   = $clog2(MDIV_N_WORDS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        UNLOAD = 2'd2
    } state_t;

endpackage

// File: rtl/mdiv_opnd_seq_if.sv
// Load and read-out handshake channels of the operand sequencer.
// The master side offers load words and consumes read-out words.
interface mdiv_opnd_seq_if
    import mdiv_pkg::*;
#(
    parameter int WORD_W = MDIV_WORD_W
);

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/mdiv_opnd_seq.sv
// Operand sequencer: streams a multi-word operand into an external word shift
// chain, and reads it back out by recirculating the chain so the stored operand
// survives the read-out unchanged.
module mdiv_opnd_seq
    import mdiv_pkg::*;
#(
    parameter int WORD_W  = MDIV_WORD_W,
    parameter int N_WORDS = MDIV_N_WORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    mdiv_opnd_seq_if.slave    bus,
    input  logic              rot_req,
    input  logic              abort,
    output logic [WORD_W-1:0] sr_din,
    output logic              sr_we,
    input  logic [WORD_W-1:0] sr_dout,
    output logic              busy,
    output logic              load_done,
    output logic              unload_done
);

    localparam int                CNT_W    = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_WORDS - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             load_hs;
    logic             unload_hs;

    assign busy = (state != IDLE);

    // Handshake qualification and shift-chain drive; abort silences every handshake.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        if (!abort) begin
            case (state)
                IDLE:    bus.in_ready  = ~rot_req;
                LOAD:    bus.in_ready  = 1'b1;
                UNLOAD:  bus.out_valid = 1'b1;
                default: ;
            endcase
        end
        if (state == UNLOAD) begin
            bus.out_data = sr_dout;
        end
        load_hs   = bus.in_valid & bus.in_ready;
        unload_hs = bus.out_valid & bus.out_ready;
        sr_we     = load_hs | unload_hs;
        if (load_hs) begin
            sr_din = bus.in_data;
        end else if (unload_hs) begin
            sr_din = sr_dout;
        end else begin
            sr_din = '0;
        end
    end

    // Sequencer state, word counter and one-cycle completion pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            load_done   <= 1'b0;
            unload_done <= 1'b0;
        end else begin
            load_done   <= 1'b0;
            unload_done <= 1'b0;
            if (abort) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rot_req) begin
                            state <= UNLOAD;
                            cnt   <= '0;
                        end else if (bus.in_valid) begin
                            state <= LOAD;
                            cnt   <= CNT_W'(1);
                        end
                    end
                    LOAD: begin
                        if (load_hs) begin
                            if (cnt == CNT_LAST) begin
                                state     <= IDLE;
                                cnt       <= '0;
                                load_done <= 1'b1;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    UNLOAD: begin
                        if (unload_hs) begin
                            if (cnt == CNT_LAST) begin
                                state       <= IDLE;
                                cnt         <= '0;
                                unload_done <= 1'b1;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mdiv_opnd_seq.sv
// Directed bench for the operand sequencer with a behavioural 8-stage shift chain.
module tb_mdiv_opnd_seq;
    import mdiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rot_req = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] sr_din;
    logic [31:0] sr_dout;
    logic        sr_we;
    logic        busy;
    logic        load_done;
    logic        unload_done;

    int errors = 0;
    int checks = 0;

    logic [31:0] chain [8];

    mdiv_opnd_seq_if #(.WORD_W(32)) bus ();

    mdiv_opnd_seq #(.WORD_W(32), .N_WORDS(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .rot_req     (rot_req),
        .abort       (abort),
        .sr_din      (sr_din),
        .sr_we       (sr_we),
        .sr_dout     (sr_dout),
        .busy        (busy),
        .load_done   (load_done),
        .unload_done (unload_done)
    );

    // Free-running clock, 10 ns period.
    always #5 clk = ~clk;

    // Downstream word shift chain: newest word enters stage 0, oldest leaves stage 7.
    always @(posedge clk) begin
        if (sr_we) begin
            chain[0] <= sr_din;
            for (int i = 1; i < 8; i++) chain[i] <= chain[i-1];
        end
    end
    assign sr_dout = chain[7];

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change at the falling edge; combinational outputs are sampled 1 ns later.
    task automatic apply_stimulus(input logic v, input logic [31:0] d, input logic r,
                                  input logic o, input logic a);
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_data   = d;
        rot_req       = r;
        bus.out_ready = o;
        abort         = a;
        #1;
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic load_words(input logic [31:0] base);
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b1, base + 32'(i), 1'b0, 1'b0, 1'b0);
            check_output($sformatf("load_ready%0d", i), 32'(bus.in_ready), 32'd1);
            check_output($sformatf("load_we%0d", i), 32'(sr_we), 32'd1);
            check_output($sformatf("load_din%0d", i), sr_din, base + 32'(i));
            next_edge();
            check_output($sformatf("load_done%0d", i), 32'(load_done), (i == 7) ? 32'd1 : 32'd0);
            check_output($sformatf("load_busy%0d", i), 32'(busy), (i == 7) ? 32'd0 : 32'd1);
        end
        apply_stimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        check_output("load_idle_we", 32'(sr_we), 32'd0);
        check_output("load_idle_din", sr_din, 32'd0);
        next_edge();
        check_output("load_done_once", 32'(load_done), 32'd0);
    endtask

    task automatic unload_words(input logic [31:0] base, input logic stall);
        apply_stimulus(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        check_output("unl_req_ready", 32'(bus.in_ready), 32'd0);
        check_output("unl_req_valid", 32'(bus.out_valid), 32'd0);
        check_output("unl_req_we", 32'(sr_we), 32'd0);
        next_edge();
        check_output("unl_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            if (stall) begin
                apply_stimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
                check_output($sformatf("stall_valid%0d", i), 32'(bus.out_valid), 32'd1);
                check_output($sformatf("stall_data%0d", i), bus.out_data, base + 32'(i));
                check_output($sformatf("stall_we%0d", i), 32'(sr_we), 32'd0);
                check_output($sformatf("stall_din%0d", i), sr_din, 32'd0);
                next_edge();
                check_output($sformatf("stall_done%0d", i), 32'(unload_done), 32'd0);
            end
            apply_stimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
            check_output($sformatf("unl_valid%0d", i), 32'(bus.out_valid), 32'd1);
            check_output($sformatf("unl_data%0d", i), bus.out_data, base + 32'(i));
            check_output($sformatf("unl_we%0d", i), 32'(sr_we), 32'd1);
            check_output($sformatf("unl_din%0d", i), sr_din, base + 32'(i));
            check_output($sformatf("unl_ready%0d", i), 32'(bus.in_ready), 32'd0);
            next_edge();
            check_output($sformatf("unl_done%0d", i), 32'(unload_done), (i == 7) ? 32'd1 : 32'd0);
        end
        apply_stimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        check_output("unl_end_busy", 32'(busy), 32'd0);
        check_output("unl_end_valid", 32'(bus.out_valid), 32'd0);
        next_edge();
        check_output("unl_done_once", 32'(unload_done), 32'd0);
    endtask

    // Directed sequence covering reset, load, unload, stall, abort, priority and reset mid-unload.
    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'd0;
        bus.out_ready = 1'b0;
        #2;
        check_output("rst_ready", 32'(bus.in_ready), 32'd1);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_load_done", 32'(load_done), 32'd0);
        check_output("rst_unload_done", 32'(unload_done), 32'd0);
        check_output("rst_we", 32'(sr_we), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        next_edge();

        load_words(32'h0000_0001);
        unload_words(32'h0000_0001, 1'b0);
        unload_words(32'h0000_0001, 1'b0);
        unload_words(32'h0000_0001, 1'b1);

        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 32'h0000_00A0 + 32'(i), 1'b0, 1'b0, 1'b0);
            next_edge();
        end
        apply_stimulus(1'b1, 32'h0000_00A3, 1'b0, 1'b0, 1'b1);
        check_output("abort_ready", 32'(bus.in_ready), 32'd0);
        check_output("abort_we", 32'(sr_we), 32'd0);
        next_edge();
        check_output("abort_busy", 32'(busy), 32'd0);
        check_output("abort_load_done", 32'(load_done), 32'd0);
        apply_stimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        check_output("abort_idle_ready", 32'(bus.in_ready), 32'd1);
        next_edge();
        load_words(32'h0000_0011);
        unload_words(32'h0000_0011, 1'b0);

        apply_stimulus(1'b1, 32'h0000_DEAD, 1'b1, 1'b0, 1'b0);
        check_output("prio_ready", 32'(bus.in_ready), 32'd0);
        check_output("prio_we", 32'(sr_we), 32'd0);
        next_edge();
        check_output("prio_busy", 32'(busy), 32'd1);
        check_output("prio_load_done", 32'(load_done), 32'd0);
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
            check_output($sformatf("prio_data%0d", i), bus.out_data, 32'h0000_0011 + 32'(i));
            check_output($sformatf("prio_valid%0d", i), 32'(bus.out_valid), 32'd1);
            next_edge();
        end
        apply_stimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        check_output("mid_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_output("mid_rst_busy", 32'(busy), 32'd0);
        check_output("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check_output("mid_rst_we", 32'(sr_we), 32'd0);
        check_output("mid_rst_done", 32'(unload_done), 32'd0);
        next_edge();
        check_output("mid_rst_done2", 32'(unload_done), 32'd0);
        apply_stimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        check_output("post_rst_ready", 32'(bus.in_ready), 32'd1);
        next_edge();
        check_output("post_rst_busy", 32'(busy), 32'd0);
        check_output("post_rst_done", 32'(unload_done), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mdiv_opnd_seq.md
MDIV_OPND_SEQ -- requirements
Module: mdiv_opnd_seq

Interface
REQ-001 Parameter WORD_W, default 32, width of one operand word.
REQ-002 Parameter N_WORDS, default 8, words per 256-bit operand held in the downstream 8-stage word shift chain.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  load word offered.
REQ-006 in_data  input  WORD_W  load word; least-significant word first.
REQ-007 in_ready  output  1  load word accepted when in_valid & in_ready.
REQ-008 rot_req  input  1  request full read-out of the stored operand (level, sampled in IDLE).
REQ-009 abort  input  1  synchronous return to IDLE.
REQ-010 sr_din  output  WORD_W  word driven into shift-chain input.
REQ-011 sr_we  output  1  shift-chain enable; one asserted cycle = one word shift.
REQ-012 sr_dout  input  WORD_W  word at shift-chain output (oldest word).
REQ-013 out_valid  output  1  read-out word valid.
REQ-014 out_data  output  WORD_W  read-out word.
REQ-015 out_ready  input  1  read-out word consumed when out_valid & out_ready.
REQ-016 busy  output  1  high in LOAD or UNLOAD.
REQ-017 load_done  output  1  one-cycle pulse after final load word.
REQ-018 unload_done  output  1  one-cycle pulse after final read-out word.

Function
REQ-019 States SHALL be IDLE, LOAD, UNLOAD; 3-bit word counter cnt (log2 N_WORDS bits).
REQ-020 IDLE: in_ready = ~rot_req; out_valid = 0; rot_req SHALL have priority over in_valid.
REQ-021 IDLE & in_valid & ~rot_req: word accepted, state -> LOAD, cnt -> 1.
REQ-022 IDLE & rot_req: state -> UNLOAD, cnt -> 0, no shift that cycle.
REQ-023 LOAD: in_ready = 1; each accepted word increments cnt; acceptance at cnt = N_WORDS-1 SHALL return to IDLE with cnt -> 0.
REQ-024 Any load acceptance (IDLE or LOAD) SHALL drive sr_we = 1 and sr_din = in_data combinationally in the same cycle; zero-cycle latency into the chain.
REQ-025 UNLOAD: out_valid = 1, out_data = sr_dout, in_ready = 0.
REQ-026 UNLOAD handshake SHALL drive sr_we = 1, sr_din = sr_dout (recirculate), cnt + 1; handshake at cnt = N_WORDS-1 returns to IDLE; after full unload chain contents equal pre-unload contents.
REQ-027 UNLOAD without out_ready: sr_we = 0, out_data held stable.
REQ-028 sr_we SHALL be 0 in every cycle without a handshake; sr_din = 0 when sr_we = 0.
REQ-029 load_done / unload_done SHALL be registered, high exactly the cycle after the final handshake.
REQ-030 abort SHALL override all handshakes: sr_we = 0, in_ready = 0, out_valid = 0 that cycle; next state IDLE, cnt 0, no done pulse; partial chain contents left as-is.
REQ-031 cnt wrap SHALL never occur outside the terminal transitions above.

Reset
REQ-032 rst_n low SHALL force state IDLE, cnt 0, load_done 0, unload_done 0 immediately; combinational outputs follow IDLE values (in_ready = ~rot_req, sr_we as REQ-024).
REQ-033 Reset mid-LOAD/UNLOAD SHALL abandon the operation; shift-chain data (unreset downstream) is unspecified.

Structure
REQ-034 Shared package mdiv_pkg SHALL hold WORD_W, N_WORDS, counter width and the state encoding (IDLE=0, LOAD=1, UNLOAD=2).
REQ-035 No sub-module; block connects beside the 8-stage shift chain at the mdiv top level.

Verification
REQ-036 Load 0x00000001..0x00000008 back-to-back -> sr_we high 8 consecutive cycles, load_done one cycle after 8th, in_ready stays 1.
REQ-037 After REQ-036 load, rot_req with out_ready=1 -> out_data 0x1,0x2..0x8 in order, unload_done once; second unload repeats identical sequence.
REQ-038 Unload with out_ready toggling 1/0 -> sr_we only on handshake cycles, out_data stable while stalled, 8 words total.
REQ-039 abort after 3 load words -> IDLE next cycle, no load_done, cnt 0; fresh 8-word load completes normally.
REQ-040 rot_req and in_valid both high in IDLE -> in_ready 0, UNLOAD entered, no word accepted.
REQ-041 rst_n low mid-UNLOAD (cnt=5) -> IDLE asynchronously, out_valid 0, no unload_done.
